// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; optional madd family
// enabled by defining MDU_MADD_EN.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CLG = $clog2(MAXC + 1);
  localparam int CW  = (CLG > 4) ? CLG : 4;
  localparam logic [CW-1:0] MUL_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_e;
  typedef enum logic [1:0] {
    ACC_NONE, ACC_ADD, ACC_SUB
  } acc_e;

  state_e        state_q, state_d;
  acc_e          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [63:0]   res_q, res_d;
  logic          wr_q, wr_d;

  logic [63:0] prod_s, prod_u, hilo;
  logic [31:0] a_abs, b_abs, b_nz, bu_nz;
  logic [31:0] qs_abs, rs_abs, qs, rs, qu, ru;

  // Sign-extended 64x64 product keeps the low 64 bits exact.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  assign a_abs  = A[31] ? (~A + 32'd1) : A;
  assign b_abs  = B[31] ? (~B + 32'd1) : B;
  assign b_nz   = (B == 32'd0) ? 32'd1 : b_abs;
  assign bu_nz  = (B == 32'd0) ? 32'd1 : B;
  assign qs_abs = a_abs / b_nz;
  assign rs_abs = a_abs % b_nz;
  assign qs     = (A[31] ^ B[31]) ? (~qs_abs + 32'd1) : qs_abs;
  assign rs     = A[31] ? (~rs_abs + 32'd1) : rs_abs;
  assign qu     = A / bu_nz;
  assign ru     = A % bu_nz;
  assign hilo   = {hi_q, lo_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          unique case (1'b1)
            (MDOp == 4'd1): begin
              state_d = S_BUSY;
              cnt_d   = MUL_N;
              res_d   = prod_s;
              wr_d    = 1'b1;
              acc_d   = ACC_NONE;
            end
            (MDOp == 4'd2): begin
              state_d = S_BUSY;
              cnt_d   = MUL_N;
              res_d   = prod_u;
              wr_d    = 1'b1;
              acc_d   = ACC_NONE;
            end
            (MDOp == 4'd3): begin
              state_d = S_BUSY;
              cnt_d   = DIV_N;
              res_d   = {rs, qs};
              wr_d    = (B != 32'd0);
              acc_d   = ACC_NONE;
            end
            (MDOp == 4'd4): begin
              state_d = S_BUSY;
              cnt_d   = DIV_N;
              res_d   = {ru, qu};
              wr_d    = (B != 32'd0);
              acc_d   = ACC_NONE;
            end
            (MDOp == 4'd5): hi_d = A;
            (MDOp == 4'd6): lo_d = A;
`ifdef MDU_MADD_EN
            // Accumulate uses HI/LO as they stand at writeback.
            (MDOp == 4'd7), (MDOp == 4'd8),
            (MDOp == 4'd9), (MDOp == 4'd10): begin
              state_d = S_BUSY;
              cnt_d   = MUL_N;
              wr_d    = 1'b1;
              res_d   = MDOp[0] ? prod_s : prod_u;
              acc_d   = (MDOp >= 4'd9) ? ACC_SUB : ACC_ADD;
            end
`endif
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          wr_d    = 1'b0;
          if (wr_q) begin
            unique case (acc_q)
              ACC_ADD: {hi_d, lo_d} = hilo + res_q;
              ACC_SUB: {hi_d, lo_d} = hilo - res_q;
              default: {hi_d, lo_d} = res_q;
            endcase
          end
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= ACC_NONE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
    end
  end

  assign Busy = (state_q == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
